dm_scan_ctrl: RTL and testbench
===============================

# dm_scan_ctrl

Parametrised LED dot-matrix scan controller: drives an ROWS×COLS matrix by time-multiplexing one-hot row strobes with per-row column data. It holds a double-buffered frame, so a new frame can be loaded at any time and is swapped in only at a frame boundary (tear-free). It also provides per-row anti-ghost blanking and optional PWM brightness. It sits between the game/display logic that produces frame bitmaps and the matrix pins.

## Interface
- ROWS, 8: number of matrix rows (2..16)
- COLS, 8: number of matrix columns (1..16)
- SCAN_CNT, 100000: clock cycles per row slot (≥ BLANK_CNT+2)
- BLANK_CNT, 4: cycles at start of each row slot with all columns off
- CNT_W, 17: width of slot counter; must hold SCAN_CNT-1

Ports:
- i_Clk  in  1  system clock
- i_Rst  in  1  asynchronous active-low reset
- i_Data  in  ROWS*COLS  frame bitmap; row r = i_Data[COLS*r +: COLS], bit=1 → LED on
- i_Load  in  1  single-cycle strobe: capture i_Data into pending buffer
- i_Bright  in  4  brightness level (used only with DM_SCAN_PWM_EN)
- o_DM_Row  out  ROWS  one-hot row strobe, active-high
- o_DM_Col  out  COLS  column drive, active-low (0 = LED on)
- o_Pend  out  1  pending frame waiting for swap
- o_fDone  out  1  one-cycle pulse on last cycle of last row slot

## Operation
- Reset: slot counter 0, row index 0 (o_DM_Row = 1), active and pending buffers all-zero, o_Pend=0, brightness register 0, o_DM_Col all-ones, o_fDone=0.
- Slot counter c_Cnt counts 0..SCAN_CNT-1 and wraps to 0. End-of-slot is c_Cnt==SCAN_CNT-1.
- At end-of-slot the row one-hot rotates left (bit ROWS-1 → bit 0). o_fDone = end-of-slot && row==ROWS-1.
- Column enable: c_Cnt ≥ BLANK_CNT (and the PWM condition when compiled in). When enabled, o_DM_Col = ~active[row]; otherwise all-ones.
- Load: on i_Load, pending ← i_Data, o_Pend ← 1. A second load before the swap overwrites pending (latest wins).
- Swap: in the o_fDone cycle, if o_Pend then active ← pending and o_Pend ← 0. The new frame is first shown from row 0 of the next frame.
- Simultaneous i_Load and swap in the same cycle: active ← old pending; pending ← i_Data; o_Pend stays 1.
- All outputs are functions of registered state only; there is no combinational path from inputs to outputs.
- Reset asserted mid-frame returns everything to reset values immediately; any pending frame is lost.

## Timing
- i_Load sampled on the rising edge; o_Pend high the following cycle.
- Row change visible one cycle after the end-of-slot edge.
- Frame period = ROWS*SCAN_CNT cycles; o_fDone period is identical.
- Swapped data appears on o_DM_Col at row 0, cycle BLANK_CNT of the next frame, i.e. BLANK_CNT+1 cycles after the o_fDone cycle.
- i_Bright is registered at c_Cnt==0 of every slot; a change takes effect at the next slot.

## Configuration
- DM_SCAN_PWM_EN defined:
  - A free-running 4-bit PWM counter increments every cycle and is reset only by i_Rst.
  - Columns are enabled only when c_Cnt ≥ BLANK_CNT and pwm_cnt < bright_reg.
  - bright 0 → fully dark; bright 15 → 15/16 duty.
- Undefined: i_Bright is ignored (port kept), no PWM counter, columns are enabled whenever c_Cnt ≥ BLANK_CNT.

## Test plan
Bench uses ROWS=4, COLS=4, SCAN_CNT=10, BLANK_CNT=2 unless noted.
- Reset release, no load: o_DM_Row sequence 0001→0010→0100→1000→0001 every 10 cycles; o_DM_Col stays 4'hF; o_fDone pulses once every 40 cycles, at c_Cnt=9 of row 3.
- Load 16'h8421 mid-frame: o_Pend=1 next cycle. Display unchanged until o_fDone; then row 0 shows o_DM_Col=4'hE from cycle 2 of the slot, row 1 shows 4'hD, and o_Pend=0.
- Blanking: with active row 0 = 4'hF, o_DM_Col=4'hF at c_Cnt 0–1 and 4'h0 at c_Cnt 2–9.
- Double load: load 16'h000F then 16'hF000 before the boundary → only 16'hF000 is displayed. A load coinciding with o_fDone → old pending swapped in, o_Pend stays 1.
- Reset mid-frame (row 2, c_Cnt 5, o_Pend=1): outputs return to o_DM_Row=0001, o_DM_Col=4'hF, o_Pend=0 without waiting for a clock edge.
- With DM_SCAN_PWM_EN, SCAN_CNT=34, i_Bright=4, row data 4'h1: column 0 low for exactly 4 of every 16 cycles after blanking. i_Bright=0 → never low.

Source files
------------

// File: rtl/dm_scan_ctrl.sv
// LED dot-matrix scan controller: one-hot row strobes, active-low columns, tear-free double-buffered frame.
// Optional PWM brightness is compiled in with `define DM_SCAN_PWM_EN.
module dm_scan_ctrl #(
    parameter int ROWS      = 8,
    parameter int COLS      = 8,
    parameter int SCAN_CNT  = 100000,
    parameter int BLANK_CNT = 4,
    parameter int CNT_W     = 17
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst,
    input  logic [ROWS*COLS-1:0]   i_Data,
    input  logic                   i_Load,
    input  logic [3:0]             i_Bright,
    output logic [ROWS-1:0]        o_DM_Row,
    output logic [COLS-1:0]        o_DM_Col,
    output logic                   o_Pend,
    output logic                   o_fDone
);

    localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(SCAN_CNT - 1);
    localparam logic [CNT_W-1:0] BLANK_C = CNT_W'(BLANK_CNT);

    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ROWS-1:0]      row_q, row_d;
    logic [ROWS*COLS-1:0] active_q, active_d;
    logic [ROWS*COLS-1:0] pending_q, pending_d;
    logic                 pend_q, pend_d;
    logic                 fdone_q, fdone_d;
    logic [COLS-1:0]      col_q, col_d;
    logic                 end_slot_s;
    logic                 col_en_s;
`ifdef DM_SCAN_PWM_EN
    logic [3:0]           pwm_q, pwm_d;
    logic [3:0]           bright_q, bright_d;
`else
    logic                 unused_bright_s;
    assign unused_bright_s = ^i_Bright;
`endif

    function automatic logic [COLS-1:0] row_bits(input logic [ROWS-1:0]      oh,
                                                 input logic [ROWS*COLS-1:0] frame);
        row_bits = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (oh[r]) begin
                row_bits = row_bits | frame[COLS*r +: COLS];
            end else begin
                row_bits = row_bits;
            end
        end
    endfunction

    // Next-state logic; outputs are precomputed from next state so they stay registered without extra latency.
    always_comb begin
        end_slot_s = (cnt_q == LAST_C);
        if (end_slot_s) begin
            cnt_d = '0;
            row_d = {row_q[ROWS-2:0], row_q[ROWS-1]};
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
            row_d = row_q;
        end

        if (fdone_q && pend_q) begin
            active_d = pending_q;
        end else begin
            active_d = active_q;
        end

        // A load in the swap cycle refills pending, so the flag stays set.
        if (i_Load) begin
            pending_d = i_Data;
            pend_d    = 1'b1;
        end else begin
            pending_d = pending_q;
            pend_d    = pend_q && !fdone_q;
        end

        fdone_d  = (cnt_d == LAST_C) && row_d[ROWS-1];
        col_en_s = (cnt_d >= BLANK_C);
`ifdef DM_SCAN_PWM_EN
        pwm_d = pwm_q + 4'd1;
        if (cnt_q == '0) begin
            bright_d = i_Bright;
        end else begin
            bright_d = bright_q;
        end
        col_en_s = col_en_s && (pwm_d < bright_d);
`endif
        if (col_en_s) begin
            col_d = ~row_bits(row_d, active_d);
        end else begin
            col_d = '1;
        end
    end

    // State and output registers.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            cnt_q     <= '0;
            row_q     <= {{(ROWS-1){1'b0}}, 1'b1};
            active_q  <= '0;
            pending_q <= '0;
            pend_q    <= 1'b0;
            fdone_q   <= 1'b0;
            col_q     <= '1;
`ifdef DM_SCAN_PWM_EN
            pwm_q     <= 4'd0;
            bright_q  <= 4'd0;
`endif
        end else begin
            cnt_q     <= cnt_d;
            row_q     <= row_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            pend_q    <= pend_d;
            fdone_q   <= fdone_d;
            col_q     <= col_d;
`ifdef DM_SCAN_PWM_EN
            pwm_q     <= pwm_d;
            bright_q  <= bright_d;
`endif
        end
    end

    assign o_DM_Row = row_q;
    assign o_DM_Col = col_q;
    assign o_Pend   = pend_q;
    assign o_fDone  = fdone_q;

endmodule

// File: tb/tb_dm_scan_ctrl.sv
// Scoreboard bench for dm_scan_ctrl (ROWS=4, COLS=4, SCAN_CNT=10, BLANK_CNT=2).
module tb_dm_scan_ctrl;

    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int SCAN  = 10;
    localparam int BLANK = 2;
    localparam int FRAME = ROWS * SCAN;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] i_Data;
    logic        i_Load;
    logic [3:0]  i_Bright;
    logic [3:0]  o_DM_Row;
    logic [3:0]  o_DM_Col;
    logic        o_Pend;
    logic        o_fDone;

    int          n_vec = 0;
    int          n_err = 0;
    int          k;
    logic [15:0] m_active, m_pending;
    logic        m_pend;
    logic [3:0]  m_bright;
    logic [9:0]  exp_q[$];
    logic [9:0]  e;

    dm_scan_ctrl #(.ROWS(ROWS), .COLS(COLS), .SCAN_CNT(SCAN), .BLANK_CNT(BLANK), .CNT_W(4)) dut (
        .i_Clk(clk), .i_Rst(rst_n), .i_Data(i_Data), .i_Load(i_Load), .i_Bright(i_Bright),
        .o_DM_Row(o_DM_Row), .o_DM_Col(o_DM_Col), .o_Pend(o_Pend), .o_fDone(o_fDone)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] expect_out();
        int         c;
        int         r;
        logic       en;
        logic [3:0] cd;
        c  = k % SCAN;
        r  = (k / SCAN) % ROWS;
        en = (c >= BLANK);
`ifdef DM_SCAN_PWM_EN
        en = en && ((k % 16) < int'(m_bright));
`endif
        cd = en ? ~m_active[r*COLS +: COLS] : 4'hF;
        return {4'(1 << r), cd, m_pend, (c == SCAN - 1) && (r == ROWS - 1)};
    endfunction

    function automatic void model_reset();
        k = 0; m_active = 16'h0; m_pending = 16'h0; m_pend = 1'b0; m_bright = 4'h0;
    endfunction

    // One clock: drive inputs, advance the model across the edge, push the expected outputs.
    task automatic step(input logic load, input logic [15:0] data);
        i_Load = load;
        i_Data = data;
        @(posedge clk);
        if ((k % FRAME) == FRAME - 1 && m_pend) begin
            m_active = m_pending;
            m_pend   = 1'b0;
        end
        if (load) begin
            m_pending = data;
            m_pend    = 1'b1;
        end
        if ((k % SCAN) == 0) m_bright = i_Bright;
        k++;
        exp_q.push_back(expect_out());
        @(negedge clk);
        i_Load = 1'b0;
    endtask

    task automatic test_reset();
        n_vec++;
        if ({o_DM_Row, o_DM_Col, o_Pend, o_fDone} !== 10'b0001_1111_0_0) begin
            n_err++;
            $display("FAIL reset got %b required %b", {o_DM_Row, o_DM_Col, o_Pend, o_fDone}, 10'b0001_1111_0_0);
        end
    endtask

    task automatic test_scan();
        int pulses = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            step(1'b0, 16'h0);
            e = exp_q.pop_front();
            pulses += int'(o_fDone);
            n_vec++;
            if ({o_DM_Row, o_DM_Col, o_Pend, o_fDone} !== e) begin
                n_err++;
                $display("FAIL scan k=%0d got %b required %b", k, {o_DM_Row, o_DM_Col, o_Pend, o_fDone}, e);
            end
        end
        n_vec++;
        if (pulses !== 2) begin
            n_err++;
            $display("FAIL fdone_count got %0d required 2", pulses);
        end
    endtask

    // Loads data_a at frame offset off_a, optional data_b at off_b (-1 = none), then runs two more frames.
    task automatic test_load(input string name, input int off_a, input logic [15:0] data_a,
                             input int off_b, input logic [15:0] data_b);
        int start = k;
        for (int i = 0; i < 4 * FRAME && (k - start) < 4 * FRAME; i++) begin
            if ((k % FRAME) == off_a && (k - start) < FRAME)
                step(1'b1, data_a);
            else if (off_b >= 0 && (k % FRAME) == off_b && (k - start) < 2 * FRAME && m_pend)
                step(1'b1, data_b);
            else
                step(1'b0, 16'h0);
            e = exp_q.pop_front();
            n_vec++;
            if ({o_DM_Row, o_DM_Col, o_Pend, o_fDone} !== e) begin
                n_err++;
                $display("FAIL %s k=%0d got %b required %b", name, k, {o_DM_Row, o_DM_Col, o_Pend, o_fDone}, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        while ((k % FRAME) != 2 * SCAN + 4) begin
            step(1'b0, 16'h0);
            e = exp_q.pop_front();
            n_vec++;
            if ({o_DM_Row, o_DM_Col, o_Pend, o_fDone} !== e) begin
                n_err++;
                $display("FAIL pre_rst k=%0d got %b required %b", k, {o_DM_Row, o_DM_Col, o_Pend, o_fDone}, e);
            end
        end
        step(1'b1, 16'h1234);
        e = exp_q.pop_front();
        n_vec++;
        if ({o_DM_Row, o_Pend} !== 5'b0100_1 || {o_DM_Row, o_DM_Col, o_Pend, o_fDone} !== e) begin
            n_err++;
            $display("FAIL pre_rst_state got %b required %b", {o_DM_Row, o_DM_Col, o_Pend, o_fDone}, e);
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({o_DM_Row, o_DM_Col, o_Pend, o_fDone} !== 10'b0001_1111_0_0) begin
            n_err++;
            $display("FAIL async_rst got %b required %b", {o_DM_Row, o_DM_Col, o_Pend, o_fDone}, 10'b0001_1111_0_0);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < FRAME + 5; i++) begin
            step(1'b0, 16'h0);
            e = exp_q.pop_front();
            n_vec++;
            if ({o_DM_Row, o_DM_Col, o_Pend, o_fDone} !== e) begin
                n_err++;
                $display("FAIL post_rst k=%0d got %b required %b", k, {o_DM_Row, o_DM_Col, o_Pend, o_fDone}, e);
            end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        i_Load   = 1'b0;
        i_Data   = 16'h0;
        i_Bright = 4'hF;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_scan();
        test_load("load", 15, 16'h8421, -1, 16'h0);
        test_load("blank", 5, 16'hFFFF, -1, 16'h0);
        test_load("double_load", 3, 16'h000F, 22, 16'hF000);
        test_load("load_at_fdone", 8, 16'h00F0, FRAME - 1, 16'h0F0F);
`ifdef DM_SCAN_PWM_EN
        i_Bright = 4'h4;
        test_load("pwm4", 1, 16'h1111, -1, 16'h0);
        i_Bright = 4'h0;
        test_load("pwm0", 1, 16'h1111, -1, 16'h0);
        i_Bright = 4'hF;
`endif
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
